// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch-stage sequencer: PC register, imem handshake, IF/ID register, redirect squash
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [1:0]  pc_src,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        fetch_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] stale_addr_q, stale_addr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;

    logic        active;
    logic        redirect;
    logic [31:0] target;
    logic        timeout;
    logic        complete;
    logic        ifid_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_valid_q <= 1'b0;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            stale_addr_q <= 32'd0;
            wait_cnt_q   <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            stale_addr_q <= stale_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
        end
    end

    // Branch wins over jump: it belongs to the older instruction in EX.
    assign target = branch_taken ? {branch_target[31:2], 2'b00}
                                 : {jump_target[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_valid_d = ifid_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        stale_addr_d = stale_addr_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        pc_src       = 2'b00;
        complete     = 1'b0;
        ifid_write   = 1'b0;

        active   = (state_q != S_IDLE) && (state_q != S_ERROR);
        redirect = active && (branch_taken || jump);

        case (state_q)
            S_FETCH:           imem_req = !stall && !redirect;
            S_WAIT, S_DISCARD: imem_req = 1'b1;
            default:           imem_req = 1'b0;
        endcase
        // A squashed request must keep its original address until it is acknowledged.
        imem_addr = (state_q == S_DISCARD) ? stale_addr_q : pc_q;

        timeout = imem_req && !imem_ready && (wait_cnt_q == WAIT_LAST);

        if (state_q != S_ERROR) begin
            if (imem_ready) begin
                wait_cnt_d = 8'd0;
            end else if (imem_req) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end

            if (timeout) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_FETCH;
                    S_FETCH: begin
                        if (imem_req && imem_ready) begin
                            complete = 1'b1;
                        end else if (imem_req) begin
                            state_d = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (redirect) begin
                            state_d      = imem_ready ? S_FETCH : S_DISCARD;
                            stale_addr_d = pc_q;
                        end else if (imem_ready) begin
                            complete = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (redirect) begin
                            state_d = S_FETCH;
                        end else if (!stall) begin
                            ifid_instr_d = hold_instr_q;
                            ifid_pc_d    = hold_pc_q;
                            ifid_valid_d = 1'b1;
                            ifid_write   = 1'b1;
                            state_d      = S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        if (imem_ready) begin
                            state_d = S_FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase

                if (complete) begin
                    pc_d = pc_q + PC_INC;
                    if (!stall) begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = pc_q;
                        ifid_valid_d = 1'b1;
                        ifid_write   = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_q;
                        state_d      = S_HOLD;
                    end
                end

                if (redirect) begin
                    pc_d         = target;
                    pc_src       = branch_taken ? 2'b01 : 2'b10;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = 32'd0;
                end else if (!stall && !ifid_write) begin
                    ifid_valid_d = 1'b0;
                end
            end
        end
    end

    assign pc          = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_error = err_q;

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer. It owns the PC register and drives the PC-source select of the IF PC mux. It issues handshaked requests to a variable-latency instruction memory and writes the IF/ID pipeline register. It applies decode-stage stalls and execute-stage branch/jump redirects, including squashing wrong-path fetches that are still in flight.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
PC_INC, 32'd4, sequential PC increment
TIMEOUT, 16, consecutive unacknowledged request cycles before fetch_error (range 2..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  ID hazard stall; IF/ID must hold
branch_taken  in  1  EX branch resolved taken (1-cycle pulse)
branch_target  in  32  branch destination
jump  in  1  jump decoded (1-cycle pulse)
jump_target  in  32  jump destination
imem_ready  in  1  imem acknowledge; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
imem_req  out  1  fetch request, combinational
imem_addr  out  32  fetch address (= pc), combinational
pc  out  32  current PC register
pc_src  out  2  00 seq, 01 branch, 10 jump; selects the PC update this cycle, combinational
ifid_instr  out  32  IF/ID instruction register
ifid_pc  out  32  IF/ID PC register (address of ifid_instr)
ifid_valid  out  1  IF/ID holds a real instruction
fetch_error  out  1  sticky imem timeout flag

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=IDLE, ifid_instr=0, ifid_pc=0, ifid_valid=0, fetch_error=0, wait_cnt=0, hold buffer cleared.
  - rst overrides every other input, including mid-request. Any in-flight imem response after reset is ignored.
- States: IDLE, FETCH, WAIT, HOLD, DISCARD, ERROR.
- Redirect:
  - redirect = branch_taken | jump. branch_taken has priority (older instruction).
  - Target low 2 bits are forced to 0.
  - In any non-IDLE, non-ERROR state, redirect sets pc<=target and pc_src=01/10 that cycle.
  - It also flushes IF/ID (ifid_valid<=0, ifid_instr<=0) and overrides stall.
- IDLE: imem_req=0; always → FETCH next cycle.
- FETCH:
  - imem_req = !stall & !redirect.
  - req & imem_ready: completion (see below).
  - req & !ready → WAIT.
  - No req: stay FETCH.
- WAIT:
  - imem_req=1; imem_addr must stay equal to pc.
  - ready & !redirect: completion.
  - ready & redirect: response discarded, pc<=target → FETCH.
  - !ready & redirect: pc<=target → DISCARD.
- Completion:
  - pc<=pc+PC_INC, pc_src=00.
  - If stall=0: ifid_instr<=imem_rdata, ifid_pc<=old pc, ifid_valid<=1 → FETCH.
  - If stall=1: instruction and old pc go to the hold buffer, IF/ID unchanged → HOLD.
- HOLD:
  - imem_req=0.
  - stall=1: hold.
  - stall=0: IF/ID<=hold buffer, valid=1 → FETCH.
  - redirect: buffer dropped, flush → FETCH.
- DISCARD:
  - imem_req=1, addr = the stale request's address. Drive the captured old pc; pc itself already holds the target.
  - On ready: data dropped → FETCH.
  - A further redirect updates pc and remains in DISCARD.
- IF/ID bubble: in any cycle with stall=0 where no instruction is written, ifid_valid<=0. With stall=1 and no redirect, IF/ID holds.
- pc changes only on completion or redirect. Otherwise pc_src=00 and pc holds.
- Timeout:
  - wait_cnt increments each cycle with imem_req & !imem_ready, and clears on ready.
  - If imem_req & !imem_ready & wait_cnt==TIMEOUT-1: → ERROR and fetch_error<=1.
  - ERROR: imem_req=0, all registers frozen, inputs ignored until rst.
- PC arithmetic is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0.

Test Plan:
- Sequential fetch: rst 2 cycles, imem_ready=1 always, rdata=pc+0x1000 → ifid_pc 0,4,8,12 with ifid_instr 0x1000,0x1004,…; pc_src=00.
- Multi-cycle imem: ready every 3rd req cycle → imem_addr stable during WAIT, pc advances by 4 per ack, ifid_valid=0 on the bubble cycles.
- Branch during WAIT: pc=8 waiting, branch_taken=1, target=0x40 → DISCARD. The late ack for 8 is dropped, next req addr=0x40, ifid_valid=0 until the 0x40 instruction arrives.
- Branch+jump same cycle: branch_target=0x80, jump_target=0x200 → pc_src=01, pc=0x80. A target of 0x83 loads 0x80.
- Stall at completion: stall=1 while ack for pc=0x10 → HOLD, IF/ID unchanged, pc=0x14. stall drops → ifid_pc=0x10. A redirect in HOLD instead → ifid_valid=0, pc=target.
- Timeout/reset: TIMEOUT=4, ready held 0 → fetch_error=1 after the 4th unacked req cycle, imem_req=0. rst=1 → pc=0, fetch_error=0, fetching restarts.
